// File: rtl/tt_reg_responder_pkg.sv
// Shared types and constants for the byte-wide register responder.
package tt_reg_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WR_BIT   = 7;
    localparam int RSVD_MSB = 6;
    localparam int RSVD_LSB = 4;
    localparam int ADDR_MSB = 3;

    localparam logic [7:0] RSP_ACK     = 8'h00;
    localparam logic [7:0] RSP_ERR_CMD = 8'hFF;
    localparam logic [7:0] RSP_ERR_TMO = 8'hFE;

endpackage

// File: rtl/tt_reg_responder_regfile.sv
// Scratch registers, read-only ID and free-running cycle counter behind one
// synchronous write port and one combinational read port.
module tt_reg_responder_regfile #(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] ID_VALUE = 8'hA5,
    parameter int         ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_only
);

    localparam int                NUM_SCR  = NUM_REGS - 2;
    localparam logic [ADDR_W-1:0] ID_ADDR  = ADDR_W'(NUM_REGS - 2);
    localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [NUM_SCR-1:0][7:0] scratch;
    logic [7:0]              cnt;

    // Counter never stalls; writes only ever target scratch slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch <= '0;
            cnt     <= '0;
        end else begin
            cnt <= cnt + 8'd1;
            for (int i = 0; i < NUM_SCR; i++) begin
                if (wr_en && wr_addr == ADDR_W'(i))
                    scratch[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_only = (rd_addr >= ID_ADDR);
        if (rd_addr == ID_ADDR)
            rd_data = ID_VALUE;
        else if (rd_addr == CNT_ADDR)
            rd_data = cnt;
        else begin
            for (int i = 0; i < NUM_SCR; i++) begin
                if (rd_addr == ADDR_W'(i))
                    rd_data = scratch[i];
            end
        end
    end

endmodule

// File: rtl/tt_reg_responder.sv
// Register-access responder: command/data bytes in over valid/ready, one
// response byte out over valid/ready; FSM and handshake live here.
module tt_reg_responder
    import tt_reg_responder_pkg::*;
#(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] ID_VALUE = 8'hA5,
    parameter int         TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        tmo_cnt;
    logic [7:0]        rd_data;
    logic              rd_only;
    logic              wr_en;
    logic              cmd_wr, cmd_legal, tmo_hit;

    assign cmd_wr    = in_data[WR_BIT];
    assign cmd_legal = (in_data[RSVD_MSB:RSVD_LSB] == '0)
                    && ({1'b0, in_data[ADDR_MSB:0]} < 5'(NUM_REGS))
                    && !(cmd_wr && rd_only);
    assign tmo_hit   = (tmo_cnt == 8'(TIMEOUT - 1));

    tt_reg_responder_regfile #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (addr_q),
        .wr_data (in_data),
        .rd_addr (in_data[ADDR_W-1:0]),
        .rd_data (rd_data),
        .rd_only (rd_only)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (cmd_legal && cmd_wr) ? DATA : RESP;
            DATA: if (in_valid || tmo_hit) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != RESP);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
        wr_en     = (state == DATA) && in_valid;
    end

    // Response fields are only loaded on the way into RESP, so they hold
    // steady for as long as the initiator backpressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            tmo_cnt  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    addr_q  <= in_data[ADDR_W-1:0];
                    tmo_cnt <= '0;
                    if (!cmd_legal) begin
                        rsp_data <= RSP_ERR_CMD;
                        rsp_err  <= 1'b1;
                    end else if (!cmd_wr) begin
                        rsp_data <= rd_data;
                        rsp_err  <= 1'b0;
                    end
                end
                DATA: begin
                    if (in_valid) begin
                        rsp_data <= RSP_ACK;
                        rsp_err  <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_data <= RSP_ERR_TMO;
                        rsp_err  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tt_reg_responder.md
Name: tt_reg_responder

Overview:
- Byte-wide register-access responder for a Tiny Tapeout user project.
- Serves read/write transactions from an external initiator (cocotb bench or host MCU driving ui_in/uio pins) over a valid/ready command channel and a valid/ready response channel.
- The top-level wrapper maps the channels onto ui_in/uio_in/uo_out/uio_out.
- Holds a small register file, a read-only ID register and a free-running cycle counter.

Parameters:
- NUM_REGS, 8, register count; power of two, 4..16; address width is clog2(NUM_REGS).
- ID_VALUE, 8'hA5, value returned by the ID register.
- TIMEOUT, 255, max cycles to wait in DATA for a write data byte; 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  initiator presents a byte on in_data.
- in_ready  output  1  responder accepts in_data this cycle when in_valid=1.
- in_data  input  8  command or write-data byte.
- rsp_valid  output  1  response byte valid on rsp_data.
- rsp_ready  input  1  initiator consumes the response when rsp_valid=1.
- rsp_data  output  8  read data or status code.
- rsp_err  output  1  qualifies rsp_data as an error code.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all scratch registers 0, counter 0, state IDLE. Outputs after reset: in_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
- Handshake: a transfer occurs on a rising edge with valid&&ready on the same channel. rsp_data and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
- Command byte: bit7 = write(1)/read(0); bits6:4 reserved, must be 0; bits3:0 = addr.
- Register map:
  - addr 0..NUM_REGS-3: R/W scratch.
  - addr NUM_REGS-2: ID, read-only.
  - addr NUM_REGS-1: 8-bit cycle counter, read-only. Increments every cycle, wraps 255->0, never stalls.
- Commands are illegal when reserved bits are nonzero, addr>=NUM_REGS, or the command writes a read-only address.
- States: IDLE, DATA, RESP.
- IDLE:
  - in_ready=1.
  - Illegal command accepted -> RESP with rsp_data=8'hFF, rsp_err=1. No write phase follows an illegal write.
  - Legal read accepted -> RESP with rsp_data = register value at the acceptance edge. For the counter, this is the value before that edge's increment.
  - Legal write accepted -> DATA; timeout counter loads 0.
- DATA:
  - in_ready=1.
  - Byte accepted -> written to the register on that edge -> RESP with rsp_data=8'h00, rsp_err=0.
  - No byte for TIMEOUT cycles -> RESP with rsp_data=8'hFE, rsp_err=1; no register change.
  - A byte accepted on the same cycle the timeout expires wins: the write completes.
- RESP:
  - in_ready=0, rsp_valid=1.
  - rsp_ready=1 -> IDLE on the next edge. Back-to-back commands are therefore accepted every other cycle at best.
- Latency: command accepted at edge N -> rsp_valid=1 from cycle N+1 (read or error). Write: data accepted at edge M -> rsp_valid at M+1.
- rst asserted mid-transaction:
  - Aborts to IDLE next edge; no response is emitted.
  - A pending write is discarded.
  - Scratch registers and counter are cleared.

Decomposition:
- Shared package tt_reg_responder_pkg holds:
  - state enum {IDLE, DATA, RESP};
  - command field positions (WR_BIT=7, RSVD_MSB=6, RSVD_LSB=4, ADDR_MSB=3);
  - response codes RSP_ACK=8'h00, RSP_ERR_CMD=8'hFF, RSP_ERR_TMO=8'hFE.
- One sub-module, tt_reg_responder_regfile:
  - scratch storage, ID mux and cycle counter;
  - synchronous write port, combinational read port, rd_only flag per address.
- FSM and handshake logic stay in the top.

Test Plan:
1. Reset, then write cmd 8'h82 + data 8'h3C, then read cmd 8'h02 -> responses 8'h00 (err=0) then 8'h3C (err=0); after reset a read of 8'h00 returns 8'h00.
2. Read 8'h06 (ID) -> 8'hA5, err=0. Write 8'h86 -> 8'hFF, err=1, no DATA phase; next byte is parsed as a new command.
3. Two reads of 8'h07 whose commands are accepted 10 cycles apart, after a response delay of 300 cycles -> second minus first = 10 mod 256; counter wrap observed.
4. Illegal cmds 8'h10 and 8'h08 (NUM_REGS=8) -> 8'hFF, err=1. Write cmd 8'h81, then hold in_valid=0 for 255 cycles -> 8'hFE, err=1, reg1 unchanged. Data arriving exactly on the expiry cycle -> 8'h00 and the write lands.
5. Backpressure: hold rsp_ready=0 for 20 cycles after a read -> rsp_valid/rsp_data stable, in_ready=0, busy=1. Release -> IDLE next cycle, in_ready=1.
6. Assert rst in DATA after write cmd 8'h83 -> next cycle IDLE, rsp_valid=0; data byte then sent is parsed as a command; reg3 reads 8'h00.
